bram_tdp_be: RTL and testbench
==============================

BRAM_TDP_BE -- requirements
Module: bram_tdp_be

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, word width in bits; it SHALL be a multiple of 8, and BYTES = DATA_WIDTH/8.
REQ-002 The block SHALL have parameter DEPTH, default 1024, number of words; ADDR_W = max(1, ceil(log2(DEPTH))).
REQ-003 The block SHALL have parameter READ_LATENCY, default 2, cycles from accepted read to valid data; legal values are 1 and 2.
REQ-004 The block SHALL have parameter WRITE_MODE, default "READ_FIRST", own-port read data on write; legal values are "READ_FIRST" and "WRITE_FIRST".
REQ-005 The block SHALL have parameter CLEAR_ON_RESET, default 1; 1 zero-fills the memory after reset.
REQ-006 The block SHALL have port clk_in, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst_in, input, 1 bit: reset, asynchronous and active-high.
REQ-008 The block SHALL have ports a_addr_in and b_addr_in, input, ADDR_W bits: port word addresses.
REQ-009 The block SHALL have ports a_din_in and b_din_in, input, DATA_WIDTH bits: write data.
REQ-010 The block SHALL have ports a_we_in and b_we_in, input, BYTES bits: per-byte write enables; bit i covers bits [8i+7:8i].
REQ-011 The block SHALL have ports a_re_in and b_re_in, input, 1 bit: read request.
REQ-012 The block SHALL have ports a_dout_out and b_dout_out, output, DATA_WIDTH bits: read data.
REQ-013 The block SHALL have ports a_valid_out and b_valid_out, output, 1 bit: a one-cycle strobe marking valid read data.
REQ-014 The block SHALL have port ready_out, output, 1 bit: 1 when the block accepts requests (RUN state).
REQ-015 The block SHALL have port collision_out, output, 1 bit: a one-cycle strobe on a same-address conflict.

Function
REQ-016 The block SHALL implement two states, CLEAR and RUN; ready_out SHALL be 1 exactly in RUN.
REQ-017 In CLEAR, the block SHALL write all-zero to address clr_cnt each cycle, with clr_cnt counting 0..DEPTH-1, then enter RUN on the cycle after address DEPTH-1 is written (DEPTH clear cycles).
REQ-018 With CLEAR_ON_RESET=0, the block SHALL enter RUN on the first clock edge after rst_in deasserts; memory contents are then undefined.
REQ-019 In CLEAR, all port requests SHALL be ignored: no write, no valid strobe, no collision.
REQ-020 In RUN, a port with any we bit set SHALL update only the enabled bytes at its address; all other bytes SHALL remain unchanged.
REQ-021 In RUN, a port with re=1 SHALL raise its valid_out exactly READ_LATENCY cycles later for one cycle, with dout_out carrying the data.
REQ-022 Back-to-back reads SHALL be accepted every cycle with no bubbles; the valid pipeline SHALL be fully pipelined.
REQ-023 dout_out SHALL hold its last value while valid_out=0.
REQ-024 For re and we on the same port and cycle, READ_FIRST SHALL return the pre-write word, and WRITE_FIRST SHALL return the word with the enabled bytes replaced by din.
REQ-025 When both ports write the same address in the same cycle, bytes enabled on both ports SHALL take port A data, and bytes enabled on one port only SHALL take that port's data.
REQ-026 When one port reads an address the other port writes in the same cycle, the reader SHALL receive the pre-write word, regardless of WRITE_MODE.
REQ-027 collision_out SHALL be 1 on the cycle after any same-address access pair in RUN where at least one port writes; it SHALL be 0 otherwise, including for read-read.
REQ-028 For addresses >= DEPTH (non-power-of-two DEPTH), writes SHALL be dropped, reads SHALL return 0 with a normal valid strobe, and no collision SHALL be flagged.
REQ-029 A write with we=0 and re=0 SHALL be no operation.

Reset
REQ-030 While rst_in=1, the block SHALL hold: state CLEAR (or RUN-pending if CLEAR_ON_RESET=0), clr_cnt=0, ready_out=0, a_valid_out=b_valid_out=0, a_dout_out=b_dout_out=0, collision_out=0, and the valid pipeline flushed.
REQ-031 Reset asserted mid-CLEAR or mid-read SHALL abort immediately: the clear restarts at address 0 and in-flight reads SHALL never produce a valid strobe.
REQ-032 Reset SHALL NOT alter memory contents except through the subsequent CLEAR sweep.

Verification
REQ-033 Defaults, release reset: ready_out rises after exactly 1024 cycles; reading address 1023 -> valid 2 cycles later with dout=0.
REQ-034 A writes 0xAABBCCDD to address 5 with we=4'b1111; A then writes 0x11223344 with we=4'b0101; B reads address 5 -> dout=0xAA22CC44 with valid at +2 cycles.
REQ-035 A and B write address 7 in the same cycle, A=0x01010101 we=1111 and B=0x02020202 we=1100; next cycle collision_out=1; read address 7 -> 0x01010101.
REQ-036 Address 9 holds 0x5; A reads address 9 with we=1111 din=0x6 in READ_FIRST -> 0x5; in WRITE_FIRST -> 0x6; a same-cycle B read -> 0x5 in both modes.
REQ-037 Reads issued on cycles 0,1,2 with rst_in pulsed on cycle 1 -> no valid strobe appears; ready_out=0 and the clear restarts at address 0.
REQ-038 DEPTH=1000, READ_LATENCY=1: write address 1001 is dropped; a read of address 1001 returns 0 with valid after 1 cycle.

Source files
------------

// File: rtl/bram_tdp_be.sv
// True dual-port RAM with per-byte write enables, a configurable read pipeline,
// optional zero-fill after reset and same-address collision reporting.
module bram_tdp_be #(
  parameter int    DATA_WIDTH     = 32,
  parameter int    DEPTH          = 1024,
  parameter int    READ_LATENCY   = 2,
  parameter string WRITE_MODE     = "READ_FIRST",
  parameter bit    CLEAR_ON_RESET = 1'b1,
  localparam int   BYTES          = DATA_WIDTH / 8,
  localparam int   ADDR_W         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [ADDR_W-1:0]     a_addr_in,
  input  logic [ADDR_W-1:0]     b_addr_in,
  input  logic [DATA_WIDTH-1:0] a_din_in,
  input  logic [DATA_WIDTH-1:0] b_din_in,
  input  logic [BYTES-1:0]      a_we_in,
  input  logic [BYTES-1:0]      b_we_in,
  input  logic                  a_re_in,
  input  logic                  b_re_in,
  output logic [DATA_WIDTH-1:0] a_dout_out,
  output logic [DATA_WIDTH-1:0] b_dout_out,
  output logic                  a_valid_out,
  output logic                  b_valid_out,
  output logic                  ready_out,
  output logic                  collision_out
);

  localparam bit                WRITE_FIRST = (WRITE_MODE == "WRITE_FIRST");
  localparam logic [ADDR_W:0]   DEPTH_LIM   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                state;
  logic [ADDR_W-1:0]     clr_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  function automatic logic [DATA_WIDTH-1:0] byte_merge(
    input logic [DATA_WIDTH-1:0] base,
    input logic [DATA_WIDTH-1:0] upd,
    input logic [BYTES-1:0]      en
  );
    logic [DATA_WIDTH-1:0] res;
    res = base;
    for (int i = 0; i < BYTES; i++)
      if (en[i]) res[8*i +: 8] = upd[8*i +: 8];
    return res;
  endfunction

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} < DEPTH_LIM;
  endfunction

  logic                  run, a_ok, b_ok, a_wr, b_wr, a_rd, b_rd, collision;
  logic [DATA_WIDTH-1:0] a_word, b_word, a_rd_word, b_rd_word;

  assign run  = (state == RUN);
  assign a_ok = in_range(a_addr_in);
  assign b_ok = in_range(b_addr_in);
  assign a_wr = run && a_ok && (|a_we_in);
  assign b_wr = run && b_ok && (|b_we_in);
  assign a_rd = run && a_re_in;
  assign b_rd = run && b_re_in;

  // Reads see the pre-write array; only the own port's bytes can bypass in WRITE_FIRST.
  assign a_word    = a_ok ? mem[a_addr_in] : '0;
  assign b_word    = b_ok ? mem[b_addr_in] : '0;
  assign a_rd_word = (WRITE_FIRST && a_ok) ? byte_merge(a_word, a_din_in, a_we_in) : a_word;
  assign b_rd_word = (WRITE_FIRST && b_ok) ? byte_merge(b_word, b_din_in, b_we_in) : b_word;

  assign collision = run && a_ok && b_ok && (a_addr_in == b_addr_in) &&
                     (a_re_in || (|a_we_in)) && (b_re_in || (|b_we_in)) &&
                     ((|a_we_in) || (|b_we_in));

  // Port A is written last so it owns bytes enabled on both ports.
  always_ff @(posedge clk_in) begin
    if (!run) begin
      if (CLEAR_ON_RESET) mem[clr_cnt] <= '0;
    end else begin
      for (int i = 0; i < BYTES; i++) begin
        if (b_wr && b_we_in[i]) mem[b_addr_in][8*i +: 8] <= b_din_in[8*i +: 8];
        if (a_wr && a_we_in[i]) mem[a_addr_in][8*i +: 8] <= a_din_in[8*i +: 8];
      end
    end
  end

  logic                  a_vld_p1, b_vld_p1, a_vld_p2, b_vld_p2;
  logic [DATA_WIDTH-1:0] a_dat_p1, b_dat_p1, a_dat_p2, b_dat_p2;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= CLEAR;
      clr_cnt       <= '0;
      a_vld_p1      <= 1'b0;
      b_vld_p1      <= 1'b0;
      a_vld_p2      <= 1'b0;
      b_vld_p2      <= 1'b0;
      a_dat_p1      <= '0;
      b_dat_p1      <= '0;
      a_dat_p2      <= '0;
      b_dat_p2      <= '0;
      collision_out <= 1'b0;
    end else begin
      if (state == CLEAR) begin
        if (!CLEAR_ON_RESET || clr_cnt == LAST_ADDR) state <= RUN;
        else clr_cnt <= clr_cnt + ADDR_W'(1);
      end
      // Stage p1: array read captured; data registers hold between reads
      a_vld_p1 <= a_rd;
      b_vld_p1 <= b_rd;
      if (a_rd) a_dat_p1 <= a_rd_word;
      if (b_rd) b_dat_p1 <= b_rd_word;
      // Stage p2: optional output register
      a_vld_p2 <= a_vld_p1;
      b_vld_p2 <= b_vld_p1;
      if (a_vld_p1) a_dat_p2 <= a_dat_p1;
      if (b_vld_p1) b_dat_p2 <= b_dat_p1;
      collision_out <= collision;
    end
  end

  assign ready_out   = run;
  assign a_dout_out  = (READ_LATENCY == 1) ? a_dat_p1 : a_dat_p2;
  assign b_dout_out  = (READ_LATENCY == 1) ? b_dat_p1 : b_dat_p2;
  assign a_valid_out = (READ_LATENCY == 1) ? a_vld_p1 : a_vld_p2;
  assign b_valid_out = (READ_LATENCY == 1) ? b_vld_p1 : b_vld_p2;

endmodule

// File: tb/tb_bram_tdp_be.sv
// Directed bench for bram_tdp_be: three configurations share clock and reset,
// expected read data is queued per port and matched against valid strobes.
module tb_bram_tdp_be;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [9:0]  a_addr [3];
  logic [9:0]  b_addr [3];
  logic [31:0] a_din  [3];
  logic [31:0] b_din  [3];
  logic [3:0]  a_we   [3];
  logic [3:0]  b_we   [3];
  logic        a_re   [3];
  logic        b_re   [3];
  logic [31:0] a_dout [3];
  logic [31:0] b_dout [3];
  logic        a_vld  [3];
  logic        b_vld  [3];
  logic        rdy    [3];
  logic        coll   [3];

  int cyc   = 0;
  int nvec  = 0;
  int nfail = 0;
  int t_rdy [3];

  typedef struct {int due; logic [31:0] data;} exp_t;
  exp_t q [6][$];

  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: defaults. Instance 1: WRITE_FIRST, no clear. Instance 2: DEPTH 1000, latency 1.
  bram_tdp_be u0 (
    .clk_in(clk), .rst_in(rst),
    .a_addr_in(a_addr[0]), .b_addr_in(b_addr[0]),
    .a_din_in(a_din[0]), .b_din_in(b_din[0]),
    .a_we_in(a_we[0]), .b_we_in(b_we[0]),
    .a_re_in(a_re[0]), .b_re_in(b_re[0]),
    .a_dout_out(a_dout[0]), .b_dout_out(b_dout[0]),
    .a_valid_out(a_vld[0]), .b_valid_out(b_vld[0]),
    .ready_out(rdy[0]), .collision_out(coll[0])
  );

  bram_tdp_be #(.DEPTH(16), .WRITE_MODE("WRITE_FIRST"), .CLEAR_ON_RESET(1'b0)) u1 (
    .clk_in(clk), .rst_in(rst),
    .a_addr_in(a_addr[1][3:0]), .b_addr_in(b_addr[1][3:0]),
    .a_din_in(a_din[1]), .b_din_in(b_din[1]),
    .a_we_in(a_we[1]), .b_we_in(b_we[1]),
    .a_re_in(a_re[1]), .b_re_in(b_re[1]),
    .a_dout_out(a_dout[1]), .b_dout_out(b_dout[1]),
    .a_valid_out(a_vld[1]), .b_valid_out(b_vld[1]),
    .ready_out(rdy[1]), .collision_out(coll[1])
  );

  bram_tdp_be #(.DEPTH(1000), .READ_LATENCY(1)) u2 (
    .clk_in(clk), .rst_in(rst),
    .a_addr_in(a_addr[2]), .b_addr_in(b_addr[2]),
    .a_din_in(a_din[2]), .b_din_in(b_din[2]),
    .a_we_in(a_we[2]), .b_we_in(b_we[2]),
    .a_re_in(a_re[2]), .b_re_in(b_re[2]),
    .a_dout_out(a_dout[2]), .b_dout_out(b_dout[2]),
    .a_valid_out(a_vld[2]), .b_valid_out(b_vld[2]),
    .ready_out(rdy[2]), .collision_out(coll[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int lat(input int i);
    return (i == 2) ? 1 : 2;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) begin
      a_addr[i] = '0; b_addr[i] = '0; a_din[i] = '0; b_din[i] = '0;
      a_we[i] = '0; b_we[i] = '0; a_re[i] = 1'b0; b_re[i] = 1'b0;
    end
  endtask

  task automatic drv(input int i, input bit port, input logic [9:0] addr,
                     input logic [31:0] din, input logic [3:0] we, input bit re);
    if (!port) begin
      a_addr[i] = addr; a_din[i] = din; a_we[i] = we; a_re[i] = re;
    end else begin
      b_addr[i] = addr; b_din[i] = din; b_we[i] = we; b_re[i] = re;
    end
  endtask

  task automatic expect_rd(input int i, input bit port, input logic [31:0] d);
    q[2*i + int'(port)].push_back('{due: cyc + lat(i), data: d});
  endtask

  task automatic rd(input int i, input bit port, input logic [9:0] addr, input logic [31:0] d);
    drv(i, port, addr, '0, '0, 1'b1);
    expect_rd(i, port, d);
  endtask

  task automatic rw(input int i, input bit port, input logic [9:0] addr,
                    input logic [31:0] din, input logic [3:0] we, input logic [31:0] d);
    drv(i, port, addr, din, we, 1'b1);
    expect_rd(i, port, d);
  endtask

  // Called on the negedge where reset has just been released.
  task automatic measure_ready(input string tag, input int idle_at);
    int c0;
    c0 = cyc;
    for (int i = 0; i < 3; i++) t_rdy[i] = -1;
    for (int n = 1; n <= 1100; n++) begin
      tick();
      if (n == idle_at) idle_all();
      if (n == 2) check({tag, "_clear_no_collision"}, coll[0], 0);
      for (int i = 0; i < 3; i++)
        if (t_rdy[i] < 0 && rdy[i]) t_rdy[i] = cyc - c0;
      if (t_rdy[0] >= 0 && t_rdy[1] >= 0 && t_rdy[2] >= 0) break;
    end
    check({tag, "_ready_cycles_u0"}, t_rdy[0], 1024);
    check({tag, "_ready_cycles_u1"}, t_rdy[1], 1);
    check({tag, "_ready_cycles_u2"}, t_rdy[2], 1000);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 6; k++) begin
      logic        v;
      logic [31:0] d;
      exp_t        e;
      v = (k % 2 == 0) ? a_vld[k/2] : b_vld[k/2];
      d = (k % 2 == 0) ? a_dout[k/2] : b_dout[k/2];
      if (v) begin
        check($sformatf("valid_expected_ch%0d", k), 32'(q[k].size() > 0), 1);
        if (q[k].size() > 0) begin
          e = q[k].pop_front();
          check($sformatf("latency_ch%0d", k), cyc, e.due);
          check($sformatf("rdata_ch%0d", k), d, e.data);
        end
      end
    end
  end

  initial begin
    idle_all();
    repeat (3) tick();
    check("rst_ready", rdy[0], 0);
    check("rst_a_valid", a_vld[0], 0);
    check("rst_a_dout", a_dout[0], 0);
    check("rst_b_dout", b_dout[0], 0);
    check("rst_collision", coll[0], 0);
    check("rst_ready_noclear", rdy[1], 0);

    // Release reset; requests on u0 during its clear sweep must be ignored.
    rst = 1'b0;
    drv(0, 1'b0, 10'd3, 32'hFFFFFFFF, 4'hF, 1'b1);
    drv(0, 1'b1, 10'd3, 32'h5A5A5A5A, 4'hF, 1'b1);
    measure_ready("boot", 4);

    idle_all(); rd(0, 1'b0, 10'd1023, 32'h0); rd(0, 1'b1, 10'd3, 32'h0); tick();
    idle_all(); rd(0, 1'b0, 10'd10, 32'h0); rd(0, 1'b1, 10'd10, 32'h0); tick();
    idle_all();
    check("read_read_no_collision", coll[0], 0);

    drv(0, 1'b0, 10'd5, 32'hAABBCCDD, 4'b1111, 1'b0); tick();
    drv(0, 1'b0, 10'd5, 32'h11223344, 4'b0101, 1'b0); tick();
    idle_all(); rd(0, 1'b1, 10'd5, 32'hAA22CC44); rd(0, 1'b0, 10'd5, 32'hAA22CC44); tick();
    idle_all(); rd(0, 1'b0, 10'd5, 32'hAA22CC44); tick();
    idle_all(); rd(0, 1'b0, 10'd5, 32'hAA22CC44); tick();
    idle_all(); tick(); tick();
    check("hold_valid_low", b_vld[0], 0);
    check("hold_dout", b_dout[0], 32'hAA22CC44);

    drv(0, 1'b0, 10'd7, 32'h01010101, 4'b1111, 1'b0);
    drv(0, 1'b1, 10'd7, 32'h02020202, 4'b1100, 1'b0); tick();
    idle_all();
    check("ww_collision", coll[0], 1);
    tick();
    check("collision_one_cycle", coll[0], 0);
    drv(0, 1'b0, 10'd8, 32'h0A0A0A0A, 4'b0011, 1'b0);
    drv(0, 1'b1, 10'd8, 32'h0B0B0B0B, 4'b1100, 1'b0); tick();
    idle_all();
    check("ww_split_collision", coll[0], 1);
    rd(0, 1'b0, 10'd7, 32'h01010101); rd(0, 1'b1, 10'd8, 32'h0B0B0A0A); tick();
    idle_all();

    drv(0, 1'b0, 10'd9, 32'h5, 4'hF, 1'b0);
    drv(1, 1'b0, 10'd9, 32'h5, 4'hF, 1'b0); tick();
    idle_all();
    rw(0, 1'b0, 10'd9, 32'h6, 4'hF, 32'h5); rd(0, 1'b1, 10'd9, 32'h5);
    rw(1, 1'b0, 10'd9, 32'h6, 4'hF, 32'h6); rd(1, 1'b1, 10'd9, 32'h5); tick();
    idle_all();
    check("rw_collision_u0", coll[0], 1);
    check("rw_collision_u1", coll[1], 1);
    rd(0, 1'b0, 10'd9, 32'h6);
    rw(1, 1'b0, 10'd9, 32'h0000AB00, 4'b0010, 32'h0000AB06); tick();
    idle_all(); rd(1, 1'b1, 10'd9, 32'h0000AB06); tick();
    idle_all();

    drv(2, 1'b0, 10'd999, 32'h12345678, 4'hF, 1'b0); tick();
    idle_all();
    drv(2, 1'b0, 10'd1001, 32'hDEADBEEF, 4'hF, 1'b0); rd(2, 1'b1, 10'd1001, 32'h0); tick();
    idle_all();
    check("oor_no_collision", coll[2], 0);
    rd(2, 1'b0, 10'd1001, 32'h0); rd(2, 1'b1, 10'd999, 32'h12345678); tick();
    idle_all();
    repeat (4) tick();

    // Reads on three consecutive cycles with reset pulsed on the middle one.
    drv(0, 1'b0, 10'd5, '0, '0, 1'b1); tick();
    rst = 1'b1;
    #1;
    check("midread_rst_ready", rdy[0], 0);
    check("midread_rst_valid", a_vld[0], 0);
    tick();
    rst = 1'b0;
    measure_ready("restart", 1);

    idle_all();
    rd(1, 1'b0, 10'd9, 32'h0000AB06); rd(0, 1'b0, 10'd5, 32'h0); rd(0, 1'b1, 10'd1023, 32'h0); tick();
    idle_all();
    repeat (5) tick();

    for (int k = 0; k < 6; k++) check($sformatf("drained_ch%0d", k), q[k].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
